// File: rtl/vga_cfg_if.sv
// Timing-set configuration port for vga_timing_gen: valid/ready offer of a full
// raster timing set, plus a one-cycle reject pulse back to the producer.
interface vga_cfg_if #(
  parameter int W = 11
);
  logic         cfg_valid;
  logic         cfg_ready;
  logic         cfg_err;
  logic [W-1:0] cfg_h_active;
  logic [W-1:0] cfg_h_fp;
  logic [W-1:0] cfg_h_sync;
  logic [W-1:0] cfg_h_bp;
  logic [W-1:0] cfg_v_active;
  logic [W-1:0] cfg_v_fp;
  logic [W-1:0] cfg_v_sync;
  logic [W-1:0] cfg_v_bp;

  modport master (
    output cfg_valid, cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp,
           cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp,
           cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Run-time reprogrammable VGA/DVI raster timing generator. New timing sets are
// validated on accept and swapped in only at frame end, so no frame is torn.
module vga_timing_gen #(
  parameter int W        = 11,
  parameter int FRAME_W  = 16,
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce,
  vga_cfg_if.slave           cfg,
  output logic [W-1:0]       x,
  output logic [W-1:0]       y,
  output logic               hs,
  output logic               vs,
  output logic               de,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);
  localparam int TW = W + 2;
  localparam logic [TW-1:0] MAX_TOT = TW'((2 ** W) - 1);

  typedef struct packed {
    logic [W-1:0] h_active;
    logic [W-1:0] h_fp;
    logic [W-1:0] h_sync;
    logic [W-1:0] h_bp;
    logic [W-1:0] v_active;
    logic [W-1:0] v_fp;
    logic [W-1:0] v_sync;
    logic [W-1:0] v_bp;
  } tset_t;

  typedef enum logic {PRIME, RUN} state_t;

  localparam tset_t DEF_SET = '{
    h_active: W'(H_ACTIVE), h_fp: W'(H_FP), h_sync: W'(H_SYNC), h_bp: W'(H_BP),
    v_active: W'(V_ACTIVE), v_fp: W'(V_FP), v_sync: W'(V_SYNC), v_bp: W'(V_BP)
  };

  function automatic logic [TW-1:0] ext(input logic [W-1:0] v);
    return {2'b00, v};
  endfunction

  state_t             state_q, state_d;
  logic [W-1:0]       x_q, x_d, y_q, y_d;
  logic [FRAME_W-1:0] fc_q, fc_d;
  logic               hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic               ls_q, ls_d, fs_q, fs_d;
  logic               pend_q, pend_d, err_q, err_d;
  tset_t              act_q, act_d, shd_q, shd_d;

  tset_t         new_set, eff;
  logic [TW-1:0] new_ht, new_vt, ht, vt;
  logic [TW-1:0] hs_beg, hs_end, vs_beg, vs_end;
  logic [W-1:0]  nx, ny;
  logic          cfg_ok, accept, x_end, y_end;

  always_comb begin
    new_set = '{
      h_active: cfg.cfg_h_active, h_fp: cfg.cfg_h_fp, h_sync: cfg.cfg_h_sync, h_bp: cfg.cfg_h_bp,
      v_active: cfg.cfg_v_active, v_fp: cfg.cfg_v_fp, v_sync: cfg.cfg_v_sync, v_bp: cfg.cfg_v_bp
    };
    new_ht = ext(new_set.h_active) + ext(new_set.h_fp) + ext(new_set.h_sync) + ext(new_set.h_bp);
    new_vt = ext(new_set.v_active) + ext(new_set.v_fp) + ext(new_set.v_sync) + ext(new_set.v_bp);
    // Porches may be zero; active/sync may not, and totals must fit the W-bit counters.
    cfg_ok = (|new_set.h_active) && (|new_set.h_sync) && (|new_set.v_active) && (|new_set.v_sync)
             && (new_ht <= MAX_TOT) && (new_vt <= MAX_TOT);
    accept = cfg.cfg_valid && !pend_q;

    ht    = ext(act_q.h_active) + ext(act_q.h_fp) + ext(act_q.h_sync) + ext(act_q.h_bp);
    vt    = ext(act_q.v_active) + ext(act_q.v_fp) + ext(act_q.v_sync) + ext(act_q.v_bp);
    x_end = (ext(x_q) == ht - 1'b1);
    y_end = (ext(y_q) == vt - 1'b1);

    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    fc_d    = fc_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    de_d    = de_q;
    ls_d    = ls_q;
    fs_d    = fs_q;
    act_d   = act_q;
    shd_d   = shd_q;
    pend_d  = pend_q;
    err_d   = accept && !cfg_ok;
    nx      = x_q;
    ny      = y_q;
    eff     = act_q;

    if (accept && cfg_ok) begin
      shd_d  = new_set;
      pend_d = 1'b1;
    end

    if (ce) begin
      if (state_q == RUN) begin
        if (x_end) begin
          nx = '0;
          ny = y_end ? '0 : y_q + 1'b1;
        end else begin
          nx = x_q + 1'b1;
        end
        if (x_end && y_end) begin
          fc_d = fc_q + 1'b1;
          // Frame boundary: the pending set takes effect from position (0,0).
          if (pend_q) begin
            eff    = shd_q;
            act_d  = shd_q;
            pend_d = 1'b0;
          end
        end
      end
      state_d = RUN;
      x_d     = nx;
      y_d     = ny;
    end

    hs_beg = ext(eff.h_active) + ext(eff.h_fp);
    hs_end = hs_beg + ext(eff.h_sync);
    vs_beg = ext(eff.v_active) + ext(eff.v_fp);
    vs_end = vs_beg + ext(eff.v_sync);

    if (ce) begin
      de_d = (nx < eff.h_active) && (ny < eff.v_active);
      hs_d = ((ext(nx) >= hs_beg) && (ext(nx) < hs_end)) ? HS_POL : !HS_POL;
      vs_d = ((ext(ny) >= vs_beg) && (ext(ny) < vs_end)) ? VS_POL : !VS_POL;
      ls_d = (nx == '0);
      fs_d = (nx == '0) && (ny == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PRIME;
      x_q     <= '0;
      y_q     <= '0;
      fc_q    <= '0;
      hs_q    <= !HS_POL;
      vs_q    <= !VS_POL;
      de_q    <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      act_q   <= DEF_SET;
      shd_q   <= DEF_SET;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      fc_q    <= fc_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
      act_q   <= act_d;
      shd_q   <= shd_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
    end
  end

  assign cfg.cfg_ready = !pend_q;
  assign cfg.cfg_err   = err_q;
  assign x             = x_q;
  assign y             = y_q;
  assign hs            = hs_q;
  assign vs            = vs_q;
  assign de            = de_q;
  assign line_start    = ls_q;
  assign frame_start   = fs_q;
  assign frame_cnt     = fc_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen, using small reset-default timings so full
// frames stay short: 16/2/4/3 x 10/1/2/3 gives HT=25, VT=16.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst_n, ce;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  vga_cfg_if #(.W(11)) cif ();
  vga_cfg_if #(.W(11)) cif2 ();

  logic [10:0] x0, y0, x1, y1;
  logic        hs0, vs0, de0, ls0, fs0, hs1, vs1, de1, ls1, fs1;
  logic [15:0] fc0, fc1;

  vga_timing_gen #(
    .W(11), .FRAME_W(16),
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(10), .V_FP(1), .V_SYNC(2), .V_BP(3),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .cfg(cif.slave),
    .x(x0), .y(y0), .hs(hs0), .vs(vs0), .de(de0),
    .line_start(ls0), .frame_start(fs0), .frame_cnt(fc0)
  );

  vga_timing_gen #(
    .W(11), .FRAME_W(16),
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(10), .V_FP(1), .V_SYNC(2), .V_BP(3),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .cfg(cif2.slave),
    .x(x1), .y(y1), .hs(hs1), .vs(vs1), .de(de1),
    .line_start(ls1), .frame_start(fs1), .frame_cnt(fc1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [10:0] ha, hf, hsy, hb, va, vf, vsy, vb);
    cif.cfg_h_active = ha;
    cif.cfg_h_fp     = hf;
    cif.cfg_h_sync   = hsy;
    cif.cfg_h_bp     = hb;
    cif.cfg_v_active = va;
    cif.cfg_v_fp     = vf;
    cif.cfg_v_sync   = vsy;
    cif.cfg_v_bp     = vb;
  endtask

  initial begin
    rst_n = 1'b0;
    ce    = 1'b0;
    cif.cfg_valid  = 1'b0;
    set_cfg(11'd0, 11'd0, 11'd0, 11'd0, 11'd0, 11'd0, 11'd0, 11'd0);
    cif2.cfg_valid = 1'b0;
    cif2.cfg_h_active = '0; cif2.cfg_h_fp = '0; cif2.cfg_h_sync = '0; cif2.cfg_h_bp = '0;
    cif2.cfg_v_active = '0; cif2.cfg_v_fp = '0; cif2.cfg_v_sync = '0; cif2.cfg_v_bp = '0;

    // Reset state
    step(1);
    chk("rst_x", x0, 0);
    chk("rst_y", y0, 0);
    chk("rst_de", de0, 0);
    chk("rst_hs", hs0, 0);
    chk("rst_vs", vs0, 0);
    chk("rst_ls", ls0, 0);
    chk("rst_fs", fs0, 0);
    chk("rst_fc", fc0, 0);
    chk("rst_ready", cif.cfg_ready, 1);
    chk("rst_err", cif.cfg_err, 0);
    chk("rst_hs_neg", hs1, 1);
    chk("rst_vs_neg", vs1, 1);

    // Released but ce=0: nothing moves, still waiting to prime
    rst_n = 1'b1;
    step(2);
    chk("hold_x", x0, 0);
    chk("hold_de", de0, 0);
    chk("hold_ls", ls0, 0);

    // PRIME then first line
    ce = 1'b1;
    step(1);
    chk("prime_x", x0, 0);
    chk("prime_de", de0, 1);
    chk("prime_ls", ls0, 1);
    chk("prime_fs", fs0, 1);
    chk("prime_hs_neg", hs1, 1);
    step(1);
    chk("x1", x0, 1);
    chk("x1_ls", ls0, 0);
    chk("x1_fs", fs0, 0);
    step(16);
    chk("x17", x0, 17);
    chk("x17_de", de0, 0);
    chk("x17_hs", hs0, 0);
    chk("x17_hs_neg", hs1, 1);
    step(1);
    chk("x18_hs", hs0, 1);
    chk("x18_hs_neg", hs1, 0);
    step(3);
    chk("x21_hs", hs0, 1);
    step(1);
    chk("x22_hs", hs0, 0);
    step(2);
    chk("x24", x0, 24);
    step(1);
    chk("wrap_x", x0, 0);
    chk("wrap_y", y0, 1);
    chk("wrap_ls", ls0, 1);
    chk("wrap_fs", fs0, 0);

    // Vertical sync window y=11..12
    step(225);
    chk("y10", y0, 10);
    chk("y10_vs", vs0, 0);
    chk("y10_de", de0, 0);
    step(25);
    chk("y11_vs", vs0, 1);
    chk("y11_vs_neg", vs1, 0);
    step(25);
    chk("y12_vs", vs0, 1);
    step(25);
    chk("y13_vs", vs0, 0);
    step(74);
    chk("fend_x", x0, 24);
    chk("fend_y", y0, 15);
    chk("fend_fc", fc0, 0);
    step(1);
    chk("f1_x", x0, 0);
    chk("f1_y", y0, 0);
    chk("f1_fc", fc0, 1);
    chk("f1_fs", fs0, 1);

    // ce toggling: advance on ce=1, hold on ce=0
    for (int i = 0; i < 4; i++) begin
      ce = 1'b1;
      step(1);
      chk("tog_x_adv", x0, i + 1);
      ce = 1'b0;
      step(1);
      chk("tog_x_hold", x0, i + 1);
      chk("tog_de_hold", de0, 1);
      chk("tog_ls_hold", ls0, 0);
    end
    ce = 1'b1;

    // Rejected configs: zero h_sync, then HT=2100 > 2047
    set_cfg(11'd8, 11'd1, 11'd0, 11'd1, 11'd6, 11'd1, 11'd1, 11'd2);
    cif.cfg_valid = 1'b1;
    step(1);
    cif.cfg_valid = 1'b0;
    chk("rej0_err", cif.cfg_err, 1);
    chk("rej0_ready", cif.cfg_ready, 1);
    step(1);
    chk("rej0_err_off", cif.cfg_err, 0);
    set_cfg(11'd2000, 11'd40, 11'd40, 11'd20, 11'd6, 11'd1, 11'd1, 11'd2);
    cif.cfg_valid = 1'b1;
    step(1);
    cif.cfg_valid = 1'b0;
    chk("rej1_err", cif.cfg_err, 1);
    chk("rej1_ready", cif.cfg_ready, 1);
    step(1);
    chk("rej1_err_off", cif.cfg_err, 0);
    chk("rej_x", x0, 8);

    // Mid-frame accept of 8/1/2/1 x 6/1/1/2 (HT=12, VT=10)
    set_cfg(11'd8, 11'd1, 11'd2, 11'd1, 11'd6, 11'd1, 11'd1, 11'd2);
    cif.cfg_valid = 1'b1;
    step(1);
    chk("acc_ready", cif.cfg_ready, 0);
    chk("acc_x", x0, 9);
    set_cfg(11'd8, 11'd1, 11'd0, 11'd1, 11'd6, 11'd1, 11'd1, 11'd2);
    step(1);
    cif.cfg_valid = 1'b0;
    chk("busy_ignored_err", cif.cfg_err, 0);
    step(14);
    chk("old_x24", x0, 24);
    step(1);
    chk("old_wrap_x", x0, 0);
    chk("old_wrap_y", y0, 1);
    step(374);
    chk("old_fend_x", x0, 24);
    chk("old_fend_y", y0, 15);
    chk("old_fend_ready", cif.cfg_ready, 0);
    step(1);
    chk("new_f_fc", fc0, 2);
    chk("new_f_ready", cif.cfg_ready, 1);
    chk("new_f_fs", fs0, 1);
    chk("new_f_de", de0, 1);
    step(8);
    chk("new_x8_de", de0, 0);
    chk("new_x8_hs", hs0, 0);
    step(1);
    chk("new_x9_hs", hs0, 1);
    step(1);
    chk("new_x10_hs", hs0, 1);
    step(1);
    chk("new_x11_hs", hs0, 0);
    step(1);
    chk("new_wrap_x", x0, 0);
    chk("new_wrap_y", y0, 1);
    step(60);
    chk("new_y6_vs", vs0, 0);
    chk("new_y6_de", de0, 0);
    step(12);
    chk("new_y7_vs", vs0, 1);
    step(12);
    chk("new_y8_vs", vs0, 0);
    step(23);
    chk("new_fend_x", x0, 11);
    chk("new_fend_y", y0, 9);

    // Accept on the frame-end cycle: applies only at the next frame end
    set_cfg(11'd12, 11'd3, 11'd1, 11'd2, 11'd5, 11'd1, 11'd1, 11'd1);
    cif.cfg_valid = 1'b1;
    step(1);
    cif.cfg_valid = 1'b0;
    chk("fe_acc_fc", fc0, 3);
    chk("fe_acc_ready", cif.cfg_ready, 0);
    step(12);
    chk("fe_acc_x", x0, 0);
    chk("fe_acc_y", y0, 1);
    step(5);

    // Async reset mid-frame with a config pending
    rst_n = 1'b0;
    #1;
    chk("mrst_x", x0, 0);
    chk("mrst_y", y0, 0);
    chk("mrst_de", de0, 0);
    chk("mrst_hs", hs0, 0);
    chk("mrst_ls", ls0, 0);
    chk("mrst_fc", fc0, 0);
    chk("mrst_ready", cif.cfg_ready, 1);
    step(1);
    chk("mrst_hold_x", x0, 0);
    rst_n = 1'b1;
    step(1);
    chk("mrst_prime_x", x0, 0);
    chk("mrst_prime_de", de0, 1);
    chk("mrst_prime_ls", ls0, 1);
    step(1);
    chk("mrst_x1", x0, 1);
    step(17);
    chk("mrst_def_x18", x0, 18);
    chk("mrst_def_hs", hs0, 1);
    step(6);
    chk("mrst_def_x24", x0, 24);
    step(1);
    chk("mrst_def_wrap_y", y0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
